// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the message-schedule slice.
//   WORD_W        : width of one message/schedule word
//   BLOCK_WORDS   : words per 512-bit block (W0..W15 loaded directly)
//   SHA256_ROUNDS : schedule words produced per block
//   state_t       : schedule FSM encoding
package sha256_pkg;

    localparam int WORD_W        = 32;
    localparam int BLOCK_WORDS   = 16;
    localparam int SHA256_ROUNDS = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2
    } state_t;

endpackage

// File: rtl/sha256_w_window.sv
// 16-word sliding window of the most recent schedule words.
// Entry 0 is the oldest (W(t-16)), entry 15 the newest (W(t-1)).
//   i_clk, i_rst : clock, synchronous active-high reset (clears window)
//   i_shift      : shift all entries down one slot and append i_din
//   i_din        : word appended at entry 15
//   o_w0/o_w1/o_w9/o_w14 : taps used by the expansion adder
module sha256_w_window
    import sha256_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_shift,
    input  logic [WORD_W-1:0] i_din,
    output logic [WORD_W-1:0] o_w0,
    output logic [WORD_W-1:0] o_w1,
    output logic [WORD_W-1:0] o_w9,
    output logic [WORD_W-1:0] o_w14
);

    logic [WORD_W-1:0] r_win [BLOCK_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                r_win[i] <= '0;
            end
        end else if (i_shift) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[BLOCK_WORDS-1] <= i_din;
        end
    end

    assign o_w0  = r_win[0];
    assign o_w1  = r_win[1];
    assign o_w9  = r_win[9];
    assign o_w14 = r_win[14];

endmodule

// File: rtl/sigm0.sv
// SHA-256 small sigma0: ROTR7 ^ ROTR18 ^ SHR3.
//   i_x : input word
//   o_y : sigma0(i_x)
module sigm0
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_x,
    output logic [WORD_W-1:0] o_y
);

    assign o_y = {i_x[6:0],  i_x[31:7]}  ^
                 {i_x[17:0], i_x[31:18]} ^
                 {3'b000,    i_x[31:3]};

endmodule

// File: rtl/sigm1.sv
// SHA-256 small sigma1: ROTR17 ^ ROTR19 ^ SHR10.
//   i_x : input word
//   o_y : sigma1(i_x)
module sigm1
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_x,
    output logic [WORD_W-1:0] o_y
);

    assign o_y = {i_x[16:0], i_x[31:17]} ^
                 {i_x[18:0], i_x[31:19]} ^
                 {10'd0,     i_x[31:10]};

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads W0..W15 from upstream, expands
// W16..W(ROUNDS-1), and presents every word through a one-entry
// registered output slot with valid/ready handshake.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_start               : begin a block (honoured in IDLE only)
//   i_word_valid, i_word  : upstream message words, o_word_ready accepts
//   o_w_valid, o_w, o_t   : schedule word W_t, i_w_ready consumes it
//   o_busy                : block in progress
//   o_done                : pulse after the final word is consumed
//
// state     | meaning
// ST_IDLE   | waiting for i_start
// ST_LOAD   | passing W0..W15 from upstream into slot and window
// ST_EXPAND | generating W16..W(ROUNDS-1), then draining the last word
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_word_valid,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_word_ready,
    output logic              o_w_valid,
    output logic [WORD_W-1:0] o_w,
    output logic [5:0]        o_t,
    input  logic              i_w_ready,
    output logic              o_busy,
    output logic              o_done
);

    // r_cnt is the index of the next word to issue; it reaches ROUNDS
    // after the last word, so it needs one bit more than o_t.
    localparam logic [6:0] LOAD_LAST = 7'(BLOCK_WORDS - 1);
    localparam logic [6:0] CNT_END   = 7'(ROUNDS);

    state_t            r_state;
    logic [6:0]        r_cnt;
    logic              r_w_valid;
    logic [WORD_W-1:0] r_w;
    logic [5:0]        r_t;
    logic              r_busy;
    logic              r_done;

    logic              w_slot_free;
    logic              w_load_acc;
    logic              w_exp_go;
    logic              w_final_acc;
    logic              w_shift;
    logic [WORD_W-1:0] w_shift_data;
    logic [WORD_W-1:0] w_tap0, w_tap1, w_tap9, w_tap14;
    logic [WORD_W-1:0] w_s0, w_s1;
    logic [WORD_W-1:0] w_exp_word;

    sha256_w_window u_window (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_shift (w_shift),
        .i_din   (w_shift_data),
        .o_w0    (w_tap0),
        .o_w1    (w_tap1),
        .o_w9    (w_tap9),
        .o_w14   (w_tap14)
    );

    sigm0 u_sigm0 (.i_x(w_tap1),  .o_y(w_s0));
    sigm1 u_sigm1 (.i_x(w_tap14), .o_y(w_s1));

    assign w_exp_word = w_s1 + w_tap9 + w_s0 + w_tap0;

    // Slot may be refilled in the same cycle its current word is consumed,
    // giving one word per cycle with no bubble at the LOAD/EXPAND boundary.
    assign w_slot_free  = !r_w_valid || i_w_ready;
    assign o_word_ready = (r_state == ST_LOAD) && w_slot_free;
    assign w_load_acc   = o_word_ready && i_word_valid;
    assign w_exp_go     = (r_state == ST_EXPAND) && w_slot_free && (r_cnt != CNT_END);
    assign w_final_acc  = (r_state == ST_EXPAND) && (r_cnt == CNT_END) && r_w_valid && i_w_ready;
    assign w_shift      = w_load_acc || w_exp_go;
    assign w_shift_data = (r_state == ST_LOAD) ? i_word : w_exp_word;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_w_valid <= 1'b0;
            r_w       <= '0;
            r_t       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_shift) begin
                r_w       <= w_shift_data;
                r_t       <= r_cnt[5:0];
                r_w_valid <= 1'b1;
                r_cnt     <= r_cnt + 7'd1;
            end else if (i_w_ready) begin
                r_w_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_LOAD;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_load_acc && (r_cnt == LOAD_LAST)) begin
                        r_state <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    if (w_final_acc) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_w_valid = r_w_valid;
    assign o_w       = r_w;
    assign o_t       = r_t;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
SHA-256 message-schedule stage: accepts one 512-bit block as sixteen 32-bit words, big-endian word order, W0 first. Emits the 64 schedule words W0..W63 one per accepted transfer to the downstream compression round. Sits between the padding/block buffer and the round datapath. Expansion uses the shared sigm0/sigm1 functions and a 16-word sliding window.

Parameters:
ROUNDS, 64, number of schedule words emitted per block; fixed for SHA-256, legal range 17..64.

Ports:
i_clk  input  1  rising-edge clock
i_rst  input  1  synchronous active-high reset
i_start  input  1  begin new block; sampled only in IDLE
i_word_valid  input  1  upstream message word valid
i_word  input  32  upstream message word (W0..W15 in order)
o_word_ready  output  1  stage accepts i_word this cycle
o_w_valid  output  1  o_w / o_t hold a valid schedule word
o_w  output  32  schedule word W_t
o_t  output  6  round index t of o_w
i_w_ready  input  1  downstream consumes o_w this cycle
o_busy  output  1  high from accepted i_start until final W accepted
o_done  output  1  one-cycle pulse on the cycle after W(ROUNDS-1) is accepted

Behaviour:
- Clock i_clk, synchronous active-high reset i_rst.
- Reset values: all outputs 0, state IDLE, window cleared, counter 0.
- States:
  - IDLE: o_word_ready=0. i_start=1 -> LOAD, t=0, o_busy=1.
  - LOAD: accepts words with i_word_valid && o_word_ready.
  - EXPAND: computes W16..W(ROUNDS-1).
- Output register: o_w/o_t/o_w_valid form a single registered slot. The slot is free when !o_w_valid || i_w_ready.
- LOAD handshake:
  - o_word_ready = slot free (combinational from state, o_w_valid and i_w_ready only; no path from i_word_valid).
  - On accept: W_t = i_word is written to the slot (o_w_valid=1 next cycle, latency 1) and shifted into the window; t increments.
  - After the accept with t=15: -> EXPAND.
- EXPAND:
  - Each cycle the slot is free, the stage computes W_t = sigm1(w[14]) + w[9] + sigm0(w[1]) + w[0] mod 2^32.
  - Window map: w[0] is oldest (W(t-16)), w[15] is newest (W(t-1)). Carries beyond bit 31 are discarded.
  - The result loads the slot and shifts into the window; t increments.
- Backpressure: while o_w_valid && !i_w_ready, o_w, o_t and o_w_valid are held stable and the window does not shift. In LOAD, o_word_ready=0.
- Completion:
  - After W(ROUNDS-1) is issued, no further words are generated.
  - When that word is accepted: o_w_valid=0, o_busy=0, o_done=1 for one cycle, -> IDLE.
- A new i_start is honoured in the same cycle o_done is high (state IDLE).
- i_start is ignored outside IDLE. i_word_valid is ignored outside LOAD.
- Simultaneous slot accept and refill: back-to-back throughput is 1 word/cycle with i_w_ready held high. There is no bubble between W15 and W16.
- Reset mid-block: the next edge with i_rst=1 clears all state. o_w_valid drops to 0 immediately after that edge, with no o_done pulse.
- o_t wraps never: max value ROUNDS-1 ≤ 63.

Decomposition:
- Shared package (sha256_pkg):
  - constants WORD_W=32, BLOCK_WORDS=16, SHA256_ROUNDS=64.
  - state encoding ST_IDLE/ST_LOAD/ST_EXPAND.
- Reuse the existing sigm0 and sigm1 modules as instances.
- One natural sub-module: sha256_w_window, the 16x32 shift register with shift enable, exposing taps w[0], w[1], w[9], w[14].
- FSM, counter and output slot stay in the top.

Test Plan:
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), i_w_ready=1 -> o_t=0..63 on consecutive cycles, o_w(16)=0x61626380, o_w(17)=0x000F0000, all 64 words match the software golden model, o_done one cycle after t=63 accepted.
- All-zero block -> all 64 o_w = 0x00000000, o_done pulses once, o_busy=0 afterwards.
- All-ones block (16 x 0xFFFFFFFF) -> o_w(16)=0x203FFFFC; checks mod-2^32 wrap of the four-term add.
- Backpressure: hold i_w_ready=0 for 5 cycles at t=3 and at t=20 -> o_w/o_t stable (t=3, t=20), o_word_ready=0 during the t=3 stall, final sequence identical to the "abc" run.
- Upstream gaps: i_word_valid toggles 1/0 during LOAD -> only valid words are accepted, o_t strictly increments, no duplicates; i_start asserted mid-block -> ignored.
- Reset at t=30 (i_rst=1 one cycle) -> o_w_valid=0, o_busy=0, no o_done. A fresh "abc" block then produces the correct full sequence.
